nth_one_select: RTL and testbench

//  Multi-cycle rank-select unit: returns the bit position of the k-th set bit (0-based, LSB first) of a word.

---
 rtl/nth_one_select_pkg.sv | 11 +
 rtl/nth_one_chunk_find.sv | 40 ++++
 rtl/nth_one_select.sv | 116 +++++++++++
 tb/tb_nth_one_select.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/nth_one_select_pkg.sv
// Shared types and helpers for the nth_one_select rank-select unit.
package nth_one_select_pkg;

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_e;

  // Index width for an n-entry range; never collapses to zero bits.
  function automatic int idx_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/nth_one_chunk_find.sv
// Combinational per-chunk rank search: popcount of the chunk and, when the
// wanted rank falls inside it, the offset of that set bit.
module nth_one_chunk_find
  import nth_one_select_pkg::*;
#(
  parameter  int CHUNK_W = 8,
  parameter  int IDX_W   = 5,
  localparam int OFF_W   = $clog2(CHUNK_W),
  localparam int CNT_W   = OFF_W + 1
) (
  input  logic [CHUNK_W-1:0] chunk,
  input  logic [IDX_W-1:0]   k_rem,
  output logic [CNT_W-1:0]   cnt,
  output logic               hit,
  output logic [OFF_W-1:0]   offset
);

  logic [CNT_W-1:0] run;
  logic             got;

  // run counts set bits strictly below p; the first set bit whose
  // preceding count equals k_rem is the k_rem-th one.
  always_comb begin
    run    = '0;
    got    = 1'b0;
    offset = '0;
    for (int p = 0; p < CHUNK_W; p++) begin
      if (chunk[p]) begin
        if (!got && (32'(run) == 32'(k_rem))) begin
          got    = 1'b1;
          offset = OFF_W'(p);
        end
        run = run + CNT_W'(1);
      end
    end
    cnt = run;
    hit = got;
  end

endmodule

// File: rtl/nth_one_select.sv
// Multi-cycle rank-select: position of the k-th set bit, CHUNK_W bits per cycle.
// Optional NTH_ONE_SELECT_ZERO_FASTPATH_EN: all-zero words skip the sweep.
module nth_one_select
  import nth_one_select_pkg::*;
#(
  parameter  int DATA_W  = 32,
  parameter  int CHUNK_W = 8,
  localparam int IDX_W   = idx_bits(DATA_W)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [IDX_W-1:0]  in_k,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_found,
  output logic [IDX_W-1:0]  out_pos
);

  localparam int NCHUNK = DATA_W / CHUNK_W;
  localparam int CI_W   = idx_bits(NCHUNK);
  localparam int OFF_W  = $clog2(CHUNK_W);
  localparam int CNT_W  = OFF_W + 1;

  state_e                           state, state_d;
  logic [NCHUNK-1:0][CHUNK_W-1:0]   data_q, data_d;
  logic [IDX_W-1:0]                 k_rem, k_d;
  logic [CI_W-1:0]                  chunk_idx, idx_d;
  logic                             found_d;
  logic [IDX_W-1:0]                 pos_d;

  logic [CNT_W-1:0]                 cnt;
  logic                             hit;
  logic [OFF_W-1:0]                 offset;
  logic                             last;

  nth_one_chunk_find #(
    .CHUNK_W (CHUNK_W),
    .IDX_W   (IDX_W)
  ) u_find (
    .chunk  (data_q[chunk_idx]),
    .k_rem  (k_rem),
    .cnt    (cnt),
    .hit    (hit),
    .offset (offset)
  );

  assign last      = (chunk_idx == CI_W'(NCHUNK - 1));
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_comb begin
    state_d = state;
    data_d  = data_q;
    k_d     = k_rem;
    idx_d   = chunk_idx;
    found_d = out_found;
    pos_d   = out_pos;
    case (state)
      IDLE: if (in_valid) begin
        data_d = in_data;
        k_d    = in_k;
        idx_d  = '0;
`ifdef NTH_ONE_SELECT_ZERO_FASTPATH_EN
        if (in_data == '0) begin
          state_d = DONE;
          found_d = 1'b0;
          pos_d   = '0;
        end else begin
          state_d = SCAN;
        end
`else
        state_d = SCAN;
`endif
      end
      SCAN: begin
        if (hit) begin
          state_d = DONE;
          found_d = 1'b1;
          // chunk_idx*CHUNK_W + offset is a plain concatenation for power-of-two chunks
          pos_d   = IDX_W'({chunk_idx, offset});
        end else if (last) begin
          state_d = DONE;
          found_d = 1'b0;
          pos_d   = '0;
        end else begin
          k_d   = k_rem - IDX_W'(cnt);
          idx_d = chunk_idx + CI_W'(1);
        end
      end
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      data_q    <= '0;
      k_rem     <= '0;
      chunk_idx <= '0;
      out_found <= 1'b0;
      out_pos   <= '0;
    end else begin
      state     <= state_d;
      data_q    <= data_d;
      k_rem     <= k_d;
      chunk_idx <= idx_d;
      out_found <= found_d;
      out_pos   <= pos_d;
    end
  end

endmodule

// File: tb/tb_nth_one_select.sv
// Directed + random scoreboard bench for nth_one_select (DATA_W=32, CHUNK_W=8).
module tb_nth_one_select;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [4:0]  in_k;
  logic        out_valid;
  logic        out_ready;
  logic        out_found;
  logic [4:0]  out_pos;

  int checks = 0;
  int errors = 0;

`ifdef NTH_ONE_SELECT_ZERO_FASTPATH_EN
  localparam int ZLAT = 1;
`else
  localparam int ZLAT = 5;
`endif

  nth_one_select #(.DATA_W(32), .CHUNK_W(8)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_k      (in_k),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_found (out_found),
    .out_pos   (out_pos)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Expected result by a straight bit walk; latency from the deciding chunk.
  task automatic ref_sel(input logic [31:0] d, input logic [4:0] k,
                         output logic f, output logic [4:0] pos, output int lat);
    int c;
    c = 0; f = 1'b0; pos = '0;
    for (int i = 0; i < 32; i++)
      if (d[i]) begin
        if (!f && c == int'(k)) begin f = 1'b1; pos = 5'(i); end
        c++;
      end
    lat = f ? 2 + int'(pos) / 8 : 5;
    if (d == 32'd0) lat = ZLAT;
  endtask

  // Called at posedge+1; returns at posedge+1. Skips the handshake when out_ready=0.
  task automatic run_op(input string tag, input logic [31:0] d, input logic [4:0] k);
    logic       f;
    logic [4:0] p;
    int         lat, exp_lat;
    ref_sel(d, k, f, p, exp_lat);
    in_valid = 1'b1; in_data = d; in_k = k;
    @(posedge clock); #1;
    in_valid = 1'b0; in_data = $urandom; in_k = 5'($urandom);
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(posedge clock); #1;
      lat++;
    end
    chk({tag, "_lat"},   lat,       exp_lat);
    chk({tag, "_found"}, out_found, f);
    chk({tag, "_pos"},   out_pos,   p);
    if (out_ready) begin
      @(posedge clock); #1;
      chk({tag, "_rdy"}, {out_valid, in_ready}, 2'b01);
    end
  endtask

  initial begin
    logic [31:0] d;
    logic        hold_f;
    logic [4:0]  hold_p;
    reset = 1'b1; in_valid = 1'b0; in_data = '0; in_k = '0; out_ready = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_in_ready",  in_ready,  1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_found",     out_found, 1'b0);
    chk("rst_pos",       out_pos,   5'd0);
    reset = 1'b0;
    @(posedge clock); #1;

    run_op("lsb",     32'h0000_0001, 5'd0);
    run_op("msb",     32'h8000_0000, 5'd0);
    run_op("ones_k8", 32'hFFFF_FFFF, 5'd8);
    run_op("ones_k31",32'hFFFF_FFFF, 5'd31);
    run_op("nib_k15", 32'h0F0F_0F0F, 5'd15);
    run_op("nib_k16", 32'h0F0F_0F0F, 5'd16);
    run_op("mid",     32'h00F0_0000, 5'd2);
    run_op("a5_k3",   32'h0000_00A5, 5'd3);
    run_op("miss",    32'h0001_0000, 5'd1);
    run_op("zero",    32'h0000_0000, 5'd0);

    // Backpressure: result held, inputs ignored while DONE.
    out_ready = 1'b0;
    run_op("bp", 32'h0000_0100, 5'd0);
    hold_f = out_found; hold_p = out_pos;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; in_data = 32'h0000_0002; in_k = 5'd0;
      @(posedge clock); #1;
      chk("bp_hold", {out_valid, in_ready, out_found, out_pos}, {2'b10, hold_f, hold_p});
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clock); #1;
    chk("bp_release", {out_valid, in_ready}, 2'b01);
    run_op("bp_next", 32'h0000_0002, 5'd0);

    // Reset in the second SCAN cycle drops the op.
    in_valid = 1'b1; in_data = 32'h8000_0000; in_k = 5'd0;
    @(posedge clock); #1;
    in_valid = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    chk("mid_rst", {out_valid, in_ready}, 2'b01);
    for (int i = 0; i < 6; i++) begin
      @(posedge clock); #1;
      chk("no_stale", out_valid, 1'b0);
    end
    run_op("post_rst", 32'h0000_0400, 5'd0);

    // Random back-to-back traffic.
    for (int n = 0; n < 40; n++) begin
      case (n % 4)
        0: d = $urandom;
        1: d = $urandom & $urandom & $urandom;
        2: d = (n % 8 == 2) ? 32'd0 : 32'(1) << $urandom_range(0, 31);
        default: d = $urandom | $urandom;
      endcase
      run_op("rand", d, 5'($urandom_range(0, 31)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
